// File: rtl/inst_fetch.sv
// Instruction fetch: one outstanding imem read, a skid slot for stalls, JAL
// resolved locally, JALR parked in JWAIT until decode supplies the target.
module inst_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  input  logic        jalr_valid,
  input  logic [63:0] jalr_target,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [63:0] PC_o
);
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  typedef enum logic [1:0] {FETCH, WAIT, HOLD, JWAIT} state_t;

  state_t      r_state, w_state_nxt;
  logic [63:0] r_pc, w_pc_nxt;
  logic [63:0] r_addr, w_addr_nxt;
  logic [63:0] r_pc_o, w_pc_o_nxt;
  logic [31:0] r_inst, w_inst_nxt;
  logic [31:0] r_skid, w_skid_nxt;
  logic        r_req, w_req_nxt;
  logic        r_flush, w_flush_nxt;
  logic        w_dlv;
  logic [31:0] w_dlv_inst;
  logic [63:0] w_jal_imm;

  // HOLD replays the skid slot; otherwise delivery comes straight off the bus
  assign w_dlv_inst = (r_state == HOLD) ? r_skid : imem_rdata;
  assign w_jal_imm  = {{44{w_dlv_inst[31]}}, w_dlv_inst[19:12], w_dlv_inst[20],
                       w_dlv_inst[30:21], 1'b0};

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_addr_nxt  = r_addr;
    w_pc_o_nxt  = r_pc_o;
    w_inst_nxt  = r_inst;
    w_skid_nxt  = r_skid;
    w_req_nxt   = r_req;
    w_flush_nxt = r_flush;
    w_dlv       = 1'b0;
    if (!stall) w_inst_nxt = NOP_INST;

    case (r_state)
      FETCH: if (!stall && !r_flush) begin
        w_req_nxt   = 1'b1;
        w_addr_nxt  = r_pc;
        w_state_nxt = WAIT;
      end
      WAIT: if (imem_ack) begin
        w_req_nxt = 1'b0;
        if (stall) begin
          w_skid_nxt  = imem_rdata;
          w_state_nxt = HOLD;
        end else begin
          w_dlv = 1'b1;
        end
      end
      HOLD:  if (!stall) w_dlv = 1'b1;
      JWAIT: if (jalr_valid) begin
        w_pc_nxt    = jalr_target;
        w_state_nxt = FETCH;
      end
      default: w_state_nxt = FETCH;
    endcase

    if (w_dlv) begin
      w_inst_nxt  = w_dlv_inst;
      w_pc_o_nxt  = r_pc;
      w_state_nxt = FETCH;
      if (w_dlv_inst[6:0] == OP_JAL)       w_pc_nxt = r_pc + w_jal_imm;
      else if (w_dlv_inst[6:0] == OP_JALR) w_state_nxt = JWAIT;
      else                                 w_pc_nxt = r_pc + 64'd4;
    end

    // the response to a flushed request only retires it
    if (r_flush && imem_ack) begin
      w_flush_nxt = 1'b0;
      w_req_nxt   = 1'b0;
    end

    // an ack arriving with the redirect is dropped; otherwise keep waiting for it
    if (branch_taken) begin
      w_pc_nxt    = branch_target;
      w_inst_nxt  = NOP_INST;
      w_pc_o_nxt  = r_pc_o;
      w_state_nxt = FETCH;
      w_req_nxt   = r_req && !imem_ack;
      w_flush_nxt = r_req && !imem_ack;
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_state <= FETCH;
      r_pc    <= RESET_PC;
      r_addr  <= RESET_PC;
      r_pc_o  <= RESET_PC;
      r_inst  <= NOP_INST;
      r_skid  <= NOP_INST;
      r_req   <= 1'b0;
      r_flush <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_addr  <= w_addr_nxt;
      r_pc_o  <= w_pc_o_nxt;
      r_inst  <= w_inst_nxt;
      r_skid  <= w_skid_nxt;
      r_req   <= w_req_nxt;
      r_flush <= w_flush_nxt;
    end
  end

  assign imem_req  = r_req;
  assign imem_addr = r_addr;
  assign inst      = r_inst;
  assign PC_o      = r_pc_o;
endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: vector table for next-PC rules, directed corner
// sequences, then random stalls/latency against an architectural PC walk.
module tb_inst_fetch;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        CLK = 1'b0, reset = 1'b1;
  logic        stall = 1'b0, branch_taken = 1'b0, jalr_valid = 1'b0, imem_ack = 1'b0;
  logic [63:0] branch_target = '0, jalr_target = '0;
  logic [31:0] imem_rdata = '0;
  logic        imem_req;
  logic [63:0] imem_addr, PC_o;
  logic [31:0] inst;

  int checks = 0, errors = 0;

  inst_fetch dut (
    .CLK(CLK), .reset(reset), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jalr_valid(jalr_valid), .jalr_target(jalr_target),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst(inst), .PC_o(PC_o)
  );

  always #5 CLK = ~CLK;

  logic [31:0] mem [logic [63:0]];
  int          mcnt = -1, mlat = 1;
  logic [63:0] maddr = '0;
  logic        rnd = 1'b0;
  logic [63:0] mpc = '0;
  int          jdue = 0, ndlv = 0;
  logic [31:0] p_inst = NOP;
  logic [63:0] p_pc = '0;

  function automatic logic [31:0] gen_inst();
    int k, off;
    logic [31:0] r;
    logic [20:0] im;
    k = $urandom_range(0, 9);
    r = $urandom;
    if (k < 7) return {r[31:7], 7'b0110011};
    if (k < 9) begin
      off = $urandom_range(1, 128) * 2;
      if ($urandom_range(0, 1) == 1) off = -off;
      im = off[20:0];
      return {im[20], im[10:1], im[11], im[19:12], 5'd1, 7'b1101111};
    end
    return {r[31:7], 7'b1100111};
  endfunction

  function automatic logic [31:0] memrd(logic [63:0] a);
    if (!mem.exists(a)) mem[a] = gen_inst();
    return mem[a];
  endfunction

  function automatic logic [63:0] arch_next(logic [63:0] p, logic [31:0] i);
    logic [63:0] imm;
    imm = {{44{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
    return (i[6:0] == 7'b1101111) ? p + imm : p + 64'd4;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // one clock: memory responder, then (random mode) the architectural checker
  task automatic tick();
    logic ps, pr;
    ps = stall;
    pr = imem_req;
    @(posedge CLK); #1;
    imem_ack = 1'b0;
    if (!reset) mcnt = -1;
    else begin
      if (mcnt < 0 && imem_req) begin
        maddr = imem_addr;
        mcnt  = rnd ? $urandom_range(1, 4) : mlat;
      end
      if (mcnt > 0) begin
        mcnt--;
        if (mcnt == 0) begin
          imem_ack = 1'b1; imem_rdata = memrd(maddr); mcnt = -1;
        end
      end
    end
    if (rnd) begin
      if (ps) begin
        chk("stall_hold_inst", 64'(inst), 64'(p_inst));
        chk("stall_hold_pc", PC_o, p_pc);
      end
      if (imem_req && !pr) chk("fetch_addr", imem_addr, mpc);
      if (inst != NOP && p_inst == NOP) begin
        chk("dlv_inst", 64'(inst), 64'(memrd(mpc)));
        chk("dlv_pc", PC_o, mpc);
        ndlv++;
        if (memrd(mpc) ==? 32'b?????????????????????????1100111) jdue = $urandom_range(1, 3);
        else mpc = arch_next(mpc, memrd(mpc));
      end
      jalr_valid = 1'b0;
      if (jdue > 0) begin
        jdue--;
        if (jdue == 0) begin
          jalr_valid  = 1'b1;
          jalr_target = 64'h1000 + 64'($urandom_range(0, 255)) * 64'd4;
          mpc = jalr_target;
        end
      end
      stall = ($urandom_range(0, 9) < 3);
    end
    p_inst = inst;
    p_pc   = PC_o;
  endtask

  task automatic wait_req(string nm, logic [63:0] exp);
    bit got;
    logic r0;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      r0 = imem_req;
      tick();
      if (imem_req && !r0) begin got = 1; chk(nm, imem_addr, exp); end
    end
    if (!got) begin checks++; errors++; $display("FAIL %s: no request within 40 cycles", nm); end
  endtask

  task automatic wait_deliv(string nm, logic [31:0] ei, logic [63:0] ep);
    bit got;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      if (inst !== NOP) begin
        got = 1;
        chk({nm, "_inst"}, 64'(inst), 64'(ei));
        chk({nm, "_pc"}, PC_o, ep);
      end
    end
    if (!got) begin checks++; errors++; $display("FAIL %s: no delivery within 40 cycles", nm); end
  endtask

  task automatic pulse_branch(logic [63:0] t);
    branch_taken = 1'b1; branch_target = t;
    tick();
    branch_taken = 1'b0;
  endtask

  typedef struct {
    logic [63:0] pc;
    logic [31:0] ins;
    logic [63:0] nxt;
    bit          jalr;
  } vec_t;

  initial begin
    vec_t tbl [6];
    tbl[0] = '{64'h10, 32'h00500093, 64'h14, 0};
    tbl[1] = '{64'h10, 32'h020000EF, 64'h30, 0};
    tbl[2] = '{64'h1000, 32'hFF9FF06F, 64'hFF8, 0};
    tbl[3] = '{64'hFFFF_FFFF_FFFF_FFFC, 32'h00700093, 64'h0, 0};
    tbl[4] = '{64'h102, 32'h00800093, 64'h106, 0};
    tbl[5] = '{64'h40, 32'h000080E7, 64'h0, 1};

    mem[64'h0] = 32'h00100093; mem[64'h4] = 32'h00200113; mem[64'h8] = 32'h00300193;

    #1 reset = 1'b0;
    #2;
    chk("rst_inst", 64'(inst), 64'(NOP));
    chk("rst_pc_o", PC_o, 64'h0);
    chk("rst_req", 64'(imem_req), 64'h0);
    repeat (2) @(posedge CLK);
    @(negedge CLK) reset = 1'b1;
    tick();
    chk("first_req", 64'(imem_req), 64'h1);
    chk("first_addr", imem_addr, 64'h0);
    wait_deliv("seq0", 32'h00100093, 64'h0);
    wait_req("seq_addr4", 64'h4);
    wait_deliv("seq1", 32'h00200113, 64'h4);
    wait_req("seq_addr8", 64'h8);
    wait_deliv("seq2", 32'h00300193, 64'h8);

    for (int k = 0; k < 6; k++) begin
      mem[tbl[k].pc] = tbl[k].ins;
      mlat = 1;
      pulse_branch(tbl[k].pc);
      wait_deliv($sformatf("tbl%0d", k), tbl[k].ins, tbl[k].pc);
      if (tbl[k].jalr) begin
        repeat (3) begin
          tick();
          chk($sformatf("tbl%0d_noreq", k), 64'(imem_req), 64'h0);
          chk($sformatf("tbl%0d_nop", k), 64'(inst), 64'(NOP));
        end
      end else begin
        wait_req($sformatf("tbl%0d_next", k), tbl[k].nxt);
      end
    end

    // JALR: two NOP cycles, then the resolved target
    pulse_branch(64'h40);
    wait_deliv("jalr", 32'h000080E7, 64'h40);
    repeat (2) begin
      tick();
      chk("jwait_nop", 64'(inst), 64'(NOP));
      chk("jwait_noreq", 64'(imem_req), 64'h0);
    end
    jalr_valid = 1'b1; jalr_target = 64'h100;
    tick();
    jalr_valid = 1'b0;
    wait_req("jalr_fetch", 64'h100);

    // stall across a 3-cycle response, then skid delivery
    mem[64'h5C] = 32'h00A00513; mem[64'h60] = 32'h00B00593; mem[64'h64] = 32'h00C00613;
    mlat = 1;
    pulse_branch(64'h5C);
    wait_deliv("pre_stall", 32'h00A00513, 64'h5C);
    mlat = 3;
    wait_req("stall_req", 64'h60);
    stall = 1'b1;
    repeat (4) begin
      tick();
      chk("stall_inst", 64'(inst), 64'(NOP));
      chk("stall_pc_o", PC_o, 64'h5C);
    end
    chk("stall_req_dropped", 64'(imem_req), 64'h0);
    stall = 1'b0;
    tick();
    chk("skid_inst", 64'(inst), 64'h00B00593);
    chk("skid_pc", PC_o, 64'h60);
    jalr_valid = 1'b1; jalr_target = 64'h700;
    tick();
    jalr_valid = 1'b0;
    chk("skid_nodup", 64'(inst), 64'(NOP));
    chk("jalr_ignored_addr", imem_addr, 64'h64);
    wait_deliv("after_skid", 32'h00C00613, 64'h64);

    // redirect while waiting: stale response discarded
    mem[64'h50] = 32'h00D00693; mem[64'h200] = 32'h00E00713;
    pulse_branch(64'h50);
    wait_req("wait50", 64'h50);
    tick();
    pulse_branch(64'h200);
    chk("flush_nop", 64'(inst), 64'(NOP));
    wait_req("flush_redirect", 64'h200);
    wait_deliv("after_flush", 32'h00E00713, 64'h200);

    // branch beats jalr in JWAIT
    mlat = 1;
    pulse_branch(64'h40);
    wait_deliv("jalr2", 32'h000080E7, 64'h40);
    tick();
    branch_taken = 1'b1; branch_target = 64'h400;
    jalr_valid = 1'b1; jalr_target = 64'h300;
    tick();
    branch_taken = 1'b0; jalr_valid = 1'b0;
    wait_req("br_over_jalr", 64'h400);

    // branch during stall flushes the held instruction
    mem[64'h480] = 32'h00F00793;
    pulse_branch(64'h480);
    wait_deliv("pre_brstall", 32'h00F00793, 64'h480);
    stall = 1'b1;
    tick();
    chk("stall_holds_dlv", 64'(inst), 64'h00F00793);
    pulse_branch(64'h500);
    chk("br_in_stall_inst", 64'(inst), 64'(NOP));
    chk("br_in_stall_pc_o", PC_o, 64'h480);
    tick();
    chk("br_in_stall_noreq", 64'(imem_req), 64'h0);
    stall = 1'b0;
    wait_req("br_in_stall_addr", 64'h500);

    // reset mid-WAIT, stale ack afterwards ignored
    mlat = 3;
    pulse_branch(64'h80);
    wait_req("pre_rst", 64'h80);
    #2 reset = 1'b0;
    #1;
    chk("midrst_req", 64'(imem_req), 64'h0);
    chk("midrst_inst", 64'(inst), 64'(NOP));
    chk("midrst_pc_o", PC_o, 64'h0);
    stall = 1'b1;
    tick();
    @(negedge CLK) reset = 1'b1;
    tick();
    chk("rst_stall_noreq", 64'(imem_req), 64'h0);
    imem_ack = 1'b1; imem_rdata = 32'hDEADBEEF;
    tick();
    chk("stale_ack_inst", 64'(inst), 64'(NOP));
    stall = 1'b0;
    wait_req("post_rst_req", 64'h0);
    wait_deliv("post_rst", 32'h00100093, 64'h0);

    // random stalls, latencies and programs against the architectural walk
    pulse_branch(64'h1000);
    mpc = 64'h1000; jdue = 0; ndlv = 0;
    rnd = 1'b1;
    repeat (4000) tick();
    rnd = 1'b0; stall = 1'b0; jalr_valid = 1'b0;
    chk("random_progress", 64'(ndlv > 100), 64'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter: RESET_PC, 64'h0, PC loaded on reset.
REQ-002 Parameter: NOP_INST, 32'h00000013, bubble instruction (addi x0,x0,0).
REQ-003 CLK  input  1  clock; all state updates on posedge CLK.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 stall  input  1  decode hazard hold (decode stall_raise); freeze outputs.
REQ-006 branch_taken  input  1  execute-stage redirect; one-cycle pulse.
REQ-007 branch_target  input  64  redirect PC, valid with branch_taken.
REQ-008 jalr_valid  input  1  decode has resolved a JALR target; one-cycle pulse.
REQ-009 jalr_target  input  64  resolved JALR PC, bit 0 already cleared.
REQ-010 imem_req  output  1  instruction memory read request.
REQ-011 imem_addr  output  64  request address, stable while imem_req is high.
REQ-012 imem_ack  input  1  read data valid; latency 1..N cycles after imem_req.
REQ-013 imem_rdata  input  32  fetched instruction, valid with imem_ack.
REQ-014 inst  output  32  instruction to decode.
REQ-015 PC_o  output  64  PC of inst.

Function
REQ-016 The FSM SHALL have the states FETCH, WAIT, HOLD, and JWAIT.
REQ-017 FETCH: imem_req=1, imem_addr=pc; the next state SHALL be WAIT unless stall is high (remain in FETCH, imem_req=0).
REQ-018 WAIT: imem_req held at 1 with the same address until imem_ack, then imem_req=0 from the following cycle.
REQ-019 On imem_ack in WAIT with stall=0: inst<=imem_rdata, PC_o<=pc, and the next state SHALL be FETCH (or JWAIT per REQ-022).
REQ-020 On imem_ack in WAIT with stall=1: capture imem_rdata into skid register and go to HOLD; inst/PC_o unchanged.
REQ-021 HOLD: on stall=0, inst<=skid, PC_o<=skid PC, and the next state SHALL be FETCH (or JWAIT); no request is issued in HOLD.
REQ-022 Next-PC on delivery, with opcode = delivered inst[6:0]:
- JAL (1101111): pc <= pc + sext({i[31],i[19:12],i[20],i[30:21],1'b0}).
- JALR (1100111): pc unchanged; the state SHALL go to JWAIT.
- Otherwise: pc <= pc + 4.
- All arithmetic is 64-bit modulo 2^64; wrap from 64'hFFFF_FFFF_FFFF_FFFC to 0 is allowed.
REQ-023 JWAIT: inst<=NOP_INST each non-stalled cycle with no request issued; on jalr_valid, pc<=jalr_target and the next state SHALL be FETCH.
REQ-024 Any cycle where no instruction is delivered and stall=0: inst<=NOP_INST, and PC_o SHALL hold its last value.
REQ-025 stall=1: inst and PC_o SHALL hold their value in every state.
REQ-026 branch_taken, in any state, SHALL override everything else that cycle:
- pc<=branch_target, inst<=NOP_INST, skid invalidated, state<=FETCH.
- If a request is outstanding (WAIT), set flush flag: the next imem_ack SHALL be discarded, and a new request SHALL be issued only after that ack.
REQ-027 branch_taken and jalr_valid together: branch wins; jalr_valid SHALL be ignored.
REQ-028 branch_taken during stall: the redirect SHALL still be taken and inst<=NOP_INST (flush overrides hold).
REQ-029 jalr_valid outside JWAIT SHALL be ignored.
REQ-030 imem_ack while not in WAIT and flush=0 SHALL be ignored.
REQ-031 Misaligned target (bit 1 set) SHALL be fetched as-is; no exception is generated.

Reset
REQ-032 On reset low, immediately:
- pc=RESET_PC, PC_o=RESET_PC, inst=NOP_INST.
- state=FETCH, imem_req=0, skid invalid, flush=0.
REQ-033 First request SHALL be issued in the first posedge after reset deasserts.
REQ-034 Reset mid-WAIT SHALL drop the outstanding request; a later stale imem_ack SHALL be ignored per REQ-030.

Verification
REQ-035 Sequential, 1-cycle memory, 3 addi instructions from RESET_PC=0 -> inst/PC_o = (i0,0), (i1,4), (i2,8) on successive deliveries; imem_addr 0,4,8.
REQ-036 JAL at PC 0x10 with imm +0x20 -> the next imem_addr SHALL be 0x30; the JAL itself is delivered with PC_o=0x10.
REQ-037 JALR at 0x40, jalr_valid 2 cycles later with target 0x100 -> 2 NOPs delivered, then a fetch from 0x100.
REQ-038 stall held 3 cycles while imem_ack arrives (3-cycle memory) -> inst frozen, then the skid instruction is delivered once the stall drops, with no duplicate and no loss.
REQ-039 branch_taken to 0x200 while in WAIT for 0x50 -> the 0x50 response is discarded, NOP is delivered, and the next imem_addr SHALL be 0x200.
REQ-040 branch_taken and jalr_valid in the same cycle during JWAIT -> pc=branch_target; jalr_target is unused.
